// File: rtl/oc_frame_accum_pkg.sv
// Shared types, widths and elaboration helpers for the frame accumulator.
package oc_frame_accum_pkg;

  // Width of the upstream 127-input ones counter output.
  localparam int unsigned CW = 7;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/oc_frame_accum_if.sv
// Count input and frame-result handshake bus of the frame accumulator.
interface oc_frame_accum_if #(
  parameter int unsigned CW    = oc_frame_accum_pkg::CW,
  parameter int unsigned ACC_W = 18
);
  logic             clear;
  logic             in_valid;
  logic [CW-1:0]    in_count;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CW-1:0]    out_min;
  logic [CW-1:0]    out_max;
  logic             out_over;

  modport master (
    output clear, in_valid, in_count, out_ready,
    input  in_ready, out_valid, out_sum, out_min, out_max, out_over
  );

  modport slave (
    input  clear, in_valid, in_count, out_ready,
    output in_ready, out_valid, out_sum, out_min, out_max, out_over
  );
endinterface

// File: rtl/oc_minmax_update.sv
// Running min/max step: folds one count into the current frame extremes.
module oc_minmax_update #(
  parameter int unsigned CW = oc_frame_accum_pkg::CW
) (
  input  logic [CW-1:0] cur_min,
  input  logic [CW-1:0] cur_max,
  input  logic [CW-1:0] in_count,
  output logic [CW-1:0] nxt_min_c,
  output logic [CW-1:0] nxt_max_c
);

  // Unsigned compare against the current extremes.
  always_comb begin
    nxt_min_c = (in_count < cur_min) ? in_count : cur_min;
    nxt_max_c = (in_count > cur_max) ? in_count : cur_max;
  end

endmodule

// File: rtl/oc_frame_accum.sv
// Accumulates FRAME_LEN ones counts into a frame sum/min/max and presents
// the result on a valid/ready output until it is taken.
module oc_frame_accum
  import oc_frame_accum_pkg::*;
#(
  parameter int unsigned CW        = oc_frame_accum_pkg::CW,
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned ACC_W     = 18,
  parameter int unsigned THRESH    = 1016
) (
  input  logic             clk,
  input  logic             rst,
  oc_frame_accum_if.slave  bus
);

  localparam int unsigned CNT_W = clog2(FRAME_LEN + 1);

  if (FRAME_LEN < 2 || FRAME_LEN > 1024) begin : g_frame_len_chk
    $error("oc_frame_accum: FRAME_LEN must be in 2..1024");
  end
  if (ACC_W < CW + clog2(FRAME_LEN) + 1) begin : g_acc_w_chk
    $error("oc_frame_accum: ACC_W too narrow for CW and FRAME_LEN");
  end

  localparam logic [CW-1:0]    MIN_INIT = {CW{1'b1}};
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic [ACC_W-1:0] THRESH_V = ACC_W'(THRESH);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [CW-1:0]    min_q, min_d;
  logic [CW-1:0]    max_q, max_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             over_q, over_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [CW-1:0]    nxt_min_c, nxt_max_c;
  logic             xfer_c, take_c;

  oc_minmax_update #(.CW(CW)) u_minmax (
    .cur_min   (min_q),
    .cur_max   (max_q),
    .in_count  (bus.in_count),
    .nxt_min_c (nxt_min_c),
    .nxt_max_c (nxt_max_c)
  );

  // Next-state and result-register update; clear outranks any handshake.
  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    min_d       = min_q;
    max_d       = max_q;
    cnt_d       = cnt_q;
    over_d      = over_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    xfer_c      = bus.in_valid & in_ready_q;
    take_c      = out_valid_q & bus.out_ready;

    if (bus.clear) begin
      state_d     = ACCUM;
      sum_d       = '0;
      min_d       = MIN_INIT;
      max_d       = '0;
      cnt_d       = '0;
      over_d      = 1'b0;
      in_ready_d  = 1'b1;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (xfer_c) begin
            sum_d  = sum_q + ACC_W'(bus.in_count);
            min_d  = nxt_min_c;
            max_d  = nxt_max_c;
            cnt_d  = cnt_q + CNT_W'(1);
            over_d = (sum_d > THRESH_V);
            if (cnt_q == LAST_IDX) begin
              state_d     = HOLD;
              in_ready_d  = 1'b0;
              out_valid_d = 1'b1;
            end
          end
        end
        HOLD: begin
          if (take_c) begin
            state_d     = ACCUM;
            sum_d       = '0;
            min_d       = MIN_INIT;
            max_d       = '0;
            cnt_d       = '0;
            over_d      = 1'b0;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      sum_q       <= '0;
      min_q       <= MIN_INIT;
      max_q       <= '0;
      cnt_q       <= '0;
      over_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      min_q       <= min_d;
      max_q       <= max_d;
      cnt_q       <= cnt_d;
      over_q      <= over_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_min   = min_q;
  assign bus.out_max   = max_q;
  assign bus.out_over  = over_q;

endmodule

// File: tb/tb_oc_frame_accum.sv
// Directed self-checking bench for oc_frame_accum (FRAME_LEN=16, THRESH=1016).
module tb_oc_frame_accum;

  localparam int unsigned CW    = 7;
  localparam int unsigned ACC_W = 18;

  logic clk;
  logic rst;

  int n_checks;
  int n_errors;

  oc_frame_accum_if #(.CW(CW), .ACC_W(ACC_W)) bus ();

  oc_frame_accum #(
    .CW(CW), .FRAME_LEN(16), .ACC_W(ACC_W), .THRESH(1016)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int n, input logic [CW-1:0] val);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_count = val;
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_sum"},       32'(bus.out_sum),   32'd0);
    check({tag, "_min"},       32'(bus.out_min),   32'd127);
    check({tag, "_max"},       32'(bus.out_max),   32'd0);
    check({tag, "_over"},      32'(bus.out_over),  32'd0);
  endtask

  int frames;
  int hold_cycles;
  logic [31:0] cap_sum, cap_min, cap_max;
  bit m_hold;
  int m_cnt;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.clear = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_count = '0;
    bus.out_ready = 1'b0;

    // Reset
    tick(); tick();
    rst = 1'b0;
    check_reset_state("rst");

    // Counts 0..15 back-to-back, out_ready=1 throughout
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = 1'b1;
      bus.in_count = CW'(i);
      tick();
      if (i == 14) check("seq_valid_before_last", 32'(bus.out_valid), 32'd0);
    end
    bus.in_valid = 1'b0;
    check("seq_out_valid", 32'(bus.out_valid), 32'd1);
    check("seq_sum",  32'(bus.out_sum),  32'd120);
    check("seq_min",  32'(bus.out_min),  32'd0);
    check("seq_max",  32'(bus.out_max),  32'd15);
    check("seq_over", 32'(bus.out_over), 32'd0);
    check("seq_in_ready_hold", 32'(bus.in_ready), 32'd0);
    tick();
    check("seq_taken_valid", 32'(bus.out_valid), 32'd0);
    check("seq_taken_ready", 32'(bus.in_ready),  32'd1);

    // 16 x 127 with back-pressure for 5 cycles, input offered while held
    bus.out_ready = 1'b0;
    feed(16, 7'd127);
    for (int c = 0; c < 5; c++) begin
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_in_ready",  32'(bus.in_ready),  32'd0);
      check("bp_sum",  32'(bus.out_sum),  32'd2032);
      check("bp_min",  32'(bus.out_min),  32'd127);
      check("bp_max",  32'(bus.out_max),  32'd127);
      check("bp_over", 32'(bus.out_over), 32'd1);
      bus.in_valid = 1'b1;
      bus.in_count = 7'd5;
      tick();
    end
    bus.in_valid = 1'b0;
    check("bp_still_valid", 32'(bus.out_valid), 32'd1);
    check("bp_still_sum",   32'(bus.out_sum),   32'd2032);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp_taken_valid", 32'(bus.out_valid), 32'd0);
    check("bp_taken_ready", 32'(bus.in_ready),  32'd1);
    check("bp_taken_sum",   32'(bus.out_sum),   32'd0);

    // in_valid toggling, counts 10/20 alternating on valid cycles
    bus.out_ready = 1'b1;
    frames = 0;
    cap_sum = '0; cap_min = '0; cap_max = '0;
    for (int c = 0; c < 32; c++) begin
      bus.in_valid = (c % 2 == 0);
      bus.in_count = (((c / 2) % 2) == 0) ? 7'd10 : 7'd20;
      tick();
      if (bus.out_valid) begin
        frames++;
        cap_sum = 32'(bus.out_sum);
        cap_min = 32'(bus.out_min);
        cap_max = 32'(bus.out_max);
      end
    end
    bus.in_valid = 1'b0;
    check("gap_frames", 32'(frames), 32'd1);
    check("gap_sum", cap_sum, 32'd240);
    check("gap_min", cap_min, 32'd10);
    check("gap_max", cap_max, 32'd20);
    tick();
    check("gap_idle_valid", 32'(bus.out_valid), 32'd0);

    // 7 x 50, then clear with an 8th valid count, then 16 x 3
    bus.out_ready = 1'b0;
    feed(7, 7'd50);
    check("clr_partial_sum", 32'(bus.out_sum), 32'd350);
    bus.in_valid = 1'b1;
    bus.in_count = 7'd50;
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    bus.in_valid = 1'b0;
    check_reset_state("clr");
    feed(15, 7'd3);
    check("clr_no_early_valid", 32'(bus.out_valid), 32'd0);
    feed(1, 7'd3);
    check("clr_out_valid", 32'(bus.out_valid), 32'd1);
    check("clr_sum", 32'(bus.out_sum), 32'd48);
    check("clr_min", 32'(bus.out_min), 32'd3);
    check("clr_max", 32'(bus.out_max), 32'd3);

    // rst while holding a result
    tick();
    check("hold_before_rst", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_state("hold_rst");

    // Continuous in_valid of 64 for 40 cycles, out_ready=1
    bus.out_ready = 1'b1;
    frames = 0;
    hold_cycles = 0;
    m_hold = 1'b0;
    m_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      bus.in_valid = 1'b1;
      bus.in_count = 7'd64;
      if (m_hold) begin
        m_hold = 1'b0;
      end else begin
        m_cnt++;
        if (m_cnt == 16) begin
          m_hold = 1'b1;
          m_cnt = 0;
        end
      end
      tick();
      check("cont_in_ready", 32'(bus.in_ready), 32'(!m_hold));
      check("cont_out_valid", 32'(bus.out_valid), 32'(m_hold));
      if (!bus.in_ready) hold_cycles++;
      if (bus.out_valid) begin
        frames++;
        check("cont_sum",  32'(bus.out_sum),  32'd1024);
        check("cont_over", 32'(bus.out_over), 32'd1);
      end
    end
    bus.in_valid = 1'b0;
    check("cont_frames", 32'(frames), 32'd2);
    check("cont_hold_cycles", 32'(hold_cycles), 32'd2);
    check("cont_partial_sum", 32'(bus.out_sum), 32'(m_cnt * 64));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/oc_frame_accum.md
Name: oc_frame_accum

Overview:
- Downstream consumer of the 127-input combinational ones counter (7-bit count, 0..127).
- Registers each per-word count under a valid/ready handshake and accumulates FRAME_LEN consecutive counts into a frame total.
- Also tracks the frame minimum and maximum, and a threshold flag.
- Presents the frame result through a valid/ready output and holds it until it is taken.

Parameters:
- CW, 7, width of incoming count (matches counter output o[6:0]).
- FRAME_LEN, 16, counts per frame; legal range 2..1024.
- ACC_W, 18, accumulator width; must be >= CW + clog2(FRAME_LEN) + 1.
- THRESH, 1016, out_over asserted when frame sum > THRESH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- clear  in  1  synchronous frame abort; discards partial frame and any held result.
- in_valid  in  1  in_count is valid.
- in_count  in  CW  ones count for one 127-bit word.
- in_ready  out  1  block can accept in_count this cycle.
- out_valid  out  1  frame result valid.
- out_ready  in  1  consumer takes result this cycle.
- out_sum  out  ACC_W  sum of FRAME_LEN counts.
- out_min  out  CW  minimum count in frame.
- out_max  out  CW  maximum count in frame.
- out_over  out  1  out_sum > THRESH.

Behaviour:
- States: ACCUM, HOLD. Reset state is ACCUM.
- Reset values: in_ready=1, out_valid=0, out_sum=0, out_min=all-ones (127), out_max=0, out_over=0, word counter=0.
- ACCUM behaviour:
  - in_ready=1 and out_valid=0.
  - A transfer occurs when in_valid & in_ready.
  - On each transfer: sum += in_count (zero-extended); min=min(min,in_count); max=max(max,in_count); word counter +1.
- ACCUM -> HOLD on the transfer that brings the word counter to FRAME_LEN.
  - The result registers are updated in that same edge (including the last count).
  - out_valid=1 from the next cycle: one-cycle latency from the last accepted count.
  - out_over is registered alongside out_sum.
- HOLD behaviour:
  - in_ready=0; input is ignored.
  - Outputs stay stable while out_valid=1 & !out_ready.
- HOLD -> ACCUM on out_valid & out_ready.
  - Same edge: sum=0, min=127, max=0, counter=0, out_valid=0.
  - in_ready=1 from the next cycle; no bubble-free overlap is required.
- clear (either state, synchronous):
  - Same effect as rst on all state and outputs.
  - Priority order: rst > clear > handshake.
  - A transfer coincident with clear is dropped.
- in_count is an unsigned count 0..127.
  - Sum cannot overflow given the ACC_W constraint; no saturation logic is needed.
  - A frame of all-127 counts at FRAME_LEN=16 gives 2032.
- Boundary cases:
  - Gaps in in_valid are allowed; only transfers count.
  - in_valid held across the ACCUM->HOLD boundary: the extra count is not accepted and stays pending for the next frame.
  - rst mid-frame discards the partial frame.
  - out_ready asserted while out_valid=0 has no effect.
- Single clock domain. No combinational path from in_valid to in_ready. out_ready affects only state.

Decomposition:
- Shared package holds:
  - state enum (ACCUM, HOLD);
  - CW=7 constant for the counter output width;
  - the clog2 helper used for ACC_W / counter width checks.
- One natural sub-module: oc_minmax_update.
  - Combinational compare; returns next min/max from the current min/max and in_count.
- Counter width is clog2(FRAME_LEN+1).
- Elaboration check: ACC_W >= CW + clog2(FRAME_LEN) + 1.

Test Plan:
- Reset, then 16 back-to-back counts 0,1,...,15 with out_ready=1.
  - Required: out_valid one cycle after the 16th transfer.
  - Required: out_sum=120, out_min=0, out_max=15, out_over=0.
- 16 counts of 127 with out_ready=0 for 5 cycles.
  - Required: out_sum=2032, min=max=127, out_over=1.
  - Required: outputs stable for 5 cycles and in_ready=0 throughout.
  - Then out_ready=1 -> out_valid=0 and in_ready=1 on the next cycle.
- in_valid toggled 1/0 every cycle over 32 cycles with counts 10,20 alternating on valid cycles.
  - Required: exactly one frame with out_sum=240, min=10, max=20.
- Feed 7 counts of 50, then pulse clear together with an 8th valid count.
  - Required: that count is dropped.
  - Then 16 counts of 3 -> out_sum=48, min=max=3.
- Assert rst while in HOLD with out_valid=1.
  - Required next cycle: out_valid=0, in_ready=1, out_sum=0, out_min=127, out_max=0.
- Hold in_valid=1 continuously for 40 cycles with count 64, out_ready=1.
  - Required: two frames with out_sum=1024 and out_over=1.
  - Required: in_ready low exactly on each HOLD cycle; no count lost or double-counted.
